// File: rtl/bq_coef_loader.sv
// -----------------------------------------------------------------------------
// bq_coef_loader
//   Wishbone master that pushes the five biquad coefficients (a11, a12, b10,
//   b11, b12) into the filter's coefficient register file. A start pulse
//   latches the values, and the block then runs five single write cycles to
//   consecutive word addresses. With BQLD_VERIFY_EN defined, all five
//   registers are read back and compared afterwards.
//
//   Build option:
//     BQLD_VERIFY_EN  compiles in the readback phase (RD state, comparator,
//                     error code 11). When undefined, the load is write-only.
//
//   Parameters:
//     COEFWIDTH  coefficient width, sign-extended to 32 bits on the bus
//     BASE_ADDR  byte address of coefficient 0 (a11)
//     TIMEOUT    max stb-high cycles without ack/err (4..255)
//
//   Ports:
//     wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//     start_i                     begin load (sampled only when idle)
//     a11_i..b12_i                coefficient values
//     wb_cyc_o .. wb_sel_o        Wishbone master outputs (all registered)
//     wb_dat_i, wb_ack_i, wb_err_i  Wishbone slave responses
//     busy_o                      load in progress
//     done_o                      one-cycle end pulse (success or failure)
//     err_o, err_code_o, err_idx_o  sticky failure report
//                                 (01 bus err, 10 timeout, 11 verify mismatch)
// -----------------------------------------------------------------------------
module bq_coef_loader #(
    parameter int          COEFWIDTH = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TIMEOUT   = 15
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_i,
    input  logic [COEFWIDTH-1:0] a11_i,
    input  logic [COEFWIDTH-1:0] a12_i,
    input  logic [COEFWIDTH-1:0] b10_i,
    input  logic [COEFWIDTH-1:0] b11_i,
    input  logic [COEFWIDTH-1:0] b12_i,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [31:0]          wb_adr_o,
    output logic [31:0]          wb_dat_o,
    output logic [3:0]           wb_sel_o,
    input  logic [31:0]          wb_dat_i,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o,
    output logic [2:0]           err_idx_o
);

    localparam logic [2:0] LAST_IDX  = 3'd4;
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [1:0] CODE_BUS  = 2'b01;
    localparam logic [1:0] CODE_TMO  = 2'b10;

`ifdef BQLD_VERIFY_EN
    localparam logic [1:0] CODE_VFY  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_GAP, S_RD, S_FIN, S_FAIL
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_GAP, S_FIN, S_FAIL
    } state_t;
`endif

    state_t                        state;
    logic [2:0]                    idx;
    logic [2:0]                    nxt_idx;
    logic [7:0]                    tmo_cnt;
    logic [4:0][COEFWIDTH-1:0]     coef_q;   // [0]=a11 .. [4]=b12

`ifdef BQLD_VERIFY_EN
    logic rd_phase;   // set once the write pass is complete
    logic wrap;       // next GAP restarts idx at 0 for the read pass

    assign nxt_idx = wrap ? 3'd0 : idx + 3'd1;
`else
    // Read data is only consumed by the readback comparator.
    logic unused_rd;
    assign unused_rd = ^wb_dat_i;

    assign nxt_idx = idx + 3'd1;
`endif

    function automatic logic [31:0] sext(input logic [COEFWIDTH-1:0] v);
        sext = {{(32-COEFWIDTH){v[COEFWIDTH-1]}}, v};
    endfunction

    function automatic logic [31:0] adr_of(input logic [2:0] i);
        adr_of = BASE_ADDR + {27'd0, i, 2'b00};
    endfunction

    function automatic logic [COEFWIDTH-1:0] coef_at(
        input logic [4:0][COEFWIDTH-1:0] c,
        input logic [2:0]                i
    );
        case (i)
            3'd0:    coef_at = c[0];
            3'd1:    coef_at = c[1];
            3'd2:    coef_at = c[2];
            3'd3:    coef_at = c[3];
            3'd4:    coef_at = c[4];
            default: coef_at = c[0];
        endcase
    endfunction

    // Single sequential block: every output is a flop, so there is no
    // combinational path from the slave responses to any output.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            idx        <= 3'd0;
            tmo_cnt    <= 8'd0;
            coef_q     <= '0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= 32'd0;
            wb_dat_o   <= 32'd0;
            wb_sel_o   <= 4'h0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= 2'b00;
            err_idx_o  <= 3'd0;
`ifdef BQLD_VERIFY_EN
            rd_phase   <= 1'b0;
            wrap       <= 1'b0;
`endif
        end else begin
            // Bus idles unless a branch below drives or holds a cycle.
            done_o   <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'h0;
            wb_adr_o <= 32'd0;
            wb_dat_o <= 32'd0;

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        coef_q     <= {b12_i, b11_i, b10_i, a12_i, a11_i};
                        idx        <= 3'd0;
                        tmo_cnt    <= 8'd0;
                        err_o      <= 1'b0;
                        err_code_o <= 2'b00;
                        err_idx_o  <= 3'd0;
                        busy_o     <= 1'b1;
`ifdef BQLD_VERIFY_EN
                        rd_phase   <= 1'b0;
                        wrap       <= 1'b0;
`endif
                        // Coefficients are not latched yet, so take a11
                        // straight from the input for the first write.
                        wb_cyc_o   <= 1'b1;
                        wb_stb_o   <= 1'b1;
                        wb_we_o    <= 1'b1;
                        wb_sel_o   <= 4'hF;
                        wb_adr_o   <= BASE_ADDR;
                        wb_dat_o   <= sext(a11_i);
                        state      <= S_WR;
                    end
                end

`ifdef BQLD_VERIFY_EN
                S_WR, S_RD: begin
`else
                S_WR: begin
`endif
                    if (wb_err_i) begin
                        // Error takes priority over a simultaneous ack.
                        state      <= S_FAIL;
                        done_o     <= 1'b1;
                        busy_o     <= 1'b0;
                        err_o      <= 1'b1;
                        err_code_o <= CODE_BUS;
                        err_idx_o  <= idx;
                    end else if (wb_ack_i) begin
`ifdef BQLD_VERIFY_EN
                        if (state == S_RD &&
                            wb_dat_i[COEFWIDTH-1:0] != coef_at(coef_q, idx)) begin
                            state      <= S_FAIL;
                            done_o     <= 1'b1;
                            busy_o     <= 1'b0;
                            err_o      <= 1'b1;
                            err_code_o <= CODE_VFY;
                            err_idx_o  <= idx;
                        end else if (idx != LAST_IDX) begin
                            state <= S_GAP;
                        end else if (!rd_phase) begin
                            // Last write done: one GAP, then read from idx 0.
                            rd_phase <= 1'b1;
                            wrap     <= 1'b1;
                            state    <= S_GAP;
                        end else begin
                            state  <= S_FIN;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end
`else
                        if (idx != LAST_IDX) begin
                            state <= S_GAP;
                        end else begin
                            state  <= S_FIN;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end
`endif
                    end else if (tmo_cnt == TMO_LAST) begin
                        // stb has now been high TIMEOUT cycles.
                        state      <= S_FAIL;
                        done_o     <= 1'b1;
                        busy_o     <= 1'b0;
                        err_o      <= 1'b1;
                        err_code_o <= CODE_TMO;
                        err_idx_o  <= idx;
                    end else begin
                        // Wait state: hold the cycle exactly as issued.
                        tmo_cnt  <= tmo_cnt + 8'd1;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= wb_we_o;
                        wb_sel_o <= 4'hF;
                        wb_adr_o <= wb_adr_o;
                        wb_dat_o <= wb_dat_o;
                    end
                end

                S_GAP: begin
                    idx      <= nxt_idx;
                    tmo_cnt  <= 8'd0;
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    wb_sel_o <= 4'hF;
                    wb_adr_o <= adr_of(nxt_idx);
`ifdef BQLD_VERIFY_EN
                    wrap     <= 1'b0;
                    if (rd_phase) begin
                        wb_we_o  <= 1'b0;
                        wb_dat_o <= 32'd0;
                        state    <= S_RD;
                    end else begin
                        wb_we_o  <= 1'b1;
                        wb_dat_o <= sext(coef_at(coef_q, nxt_idx));
                        state    <= S_WR;
                    end
`else
                    wb_we_o  <= 1'b1;
                    wb_dat_o <= sext(coef_at(coef_q, nxt_idx));
                    state    <= S_WR;
`endif
                end

                S_FIN, S_FAIL: begin
                    state <= S_IDLE;
                end

                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bq_coef_loader.sv
// -----------------------------------------------------------------------------
// tb_bq_coef_loader
//   Directed bench for bq_coef_loader with a small Wishbone slave model whose
//   wait states, missing acks, error responses and readback corruption are
//   set per coefficient index. Expected values are hand-written constants.
// -----------------------------------------------------------------------------
module tb_bq_coef_loader;

`ifdef BQLD_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        start_i  = 1'b0;
    logic [15:0] a11_i = 16'h0, a12_i = 16'h0, b10_i = 16'h0, b11_i = 16'h0, b12_i = 16'h0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;
    logic        busy_o, done_o, err_o;
    logic [1:0]  err_code_o;
    logic [2:0]  err_idx_o;

    always #5 wb_clk_i = ~wb_clk_i;

    bq_coef_loader dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i),
        .a11_i(a11_i), .a12_i(a12_i), .b10_i(b10_i), .b11_i(b11_i), .b12_i(b12_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .err_code_o(err_code_o), .err_idx_o(err_idx_o)
    );

    // ---------------- slave model ----------------
    int          wait_cyc [0:7];
    int          noack_at   = -1;
    int          err_at     = -1;
    int          corrupt_at = -1;
    logic        force_ack  = 1'b0;
    int          s_cnt      = 0;
    logic [31:0] mem [0:7];
    logic [31:0] s_off;
    logic [2:0]  s_idx;

    assign s_off    = wb_adr_o - BASE;
    assign s_idx    = s_off[4:2];
    assign wb_ack_i = (wb_cyc_o && wb_stb_o && s_cnt >= wait_cyc[s_idx] &&
                       int'(s_idx) != noack_at) || force_ack;
    assign wb_err_i = wb_cyc_o && wb_stb_o && int'(s_idx) == err_at &&
                      s_cnt >= wait_cyc[s_idx];
    assign wb_dat_i = (wb_stb_o && !wb_we_o) ?
                      (mem[s_idx] ^ ((int'(s_idx) == corrupt_at) ? 32'h1 : 32'h0)) : 32'h0;

    always @(posedge wb_clk_i) begin
        s_cnt <= (wb_stb_o && !(wb_ack_i || wb_err_i)) ? s_cnt + 1 : 0;
        if (wb_stb_o && wb_we_o && wb_ack_i && !wb_err_i) mem[s_idx] <= wb_dat_o;
    end

    // ---------------- bus monitor ----------------
    logic [31:0] wlog_adr [$];
    logic [31:0] wlog_dat [$];
    int          run = 0, max_run = 0, unstable = 0;
    logic        p_stb = 1'b0;
    logic [31:0] p_adr = 32'h0, p_dat = 32'h0;

    always @(posedge wb_clk_i) begin
        if (wb_stb_o) begin
            run = p_stb ? run + 1 : 1;
            if (run > max_run) max_run = run;
            if (p_stb && (wb_adr_o != p_adr || wb_dat_o != p_dat)) unstable++;
            if (wb_we_o && wb_ack_i && !wb_err_i) begin
                wlog_adr.push_back(wb_adr_o);
                wlog_dat.push_back(wb_dat_o);
            end
        end
        p_stb = wb_stb_o;
        p_adr = wb_adr_o;
        p_dat = wb_dat_o;
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_adr [0:4];
    logic [31:0] exp_dat [0:4];

    task automatic check_writes(input string tag, input int n);
        chk({tag, "_wcnt"}, 32'(wlog_adr.size()), 32'(n));
        for (int i = 0; i < n && i < wlog_adr.size(); i++) begin
            chk($sformatf("%s_adr%0d", tag, i), wlog_adr[i], exp_adr[i]);
            chk($sformatf("%s_dat%0d", tag, i), wlog_dat[i], exp_dat[i]);
        end
    endtask

    task automatic clear_slave();
        for (int i = 0; i < 8; i++) wait_cyc[i] = 0;
        noack_at = -1; err_at = -1; corrupt_at = -1;
        wlog_adr.delete(); wlog_dat.delete();
        max_run = 0; unstable = 0;
    endtask

    // Start a load and count cycles after the accepting edge (k = 1 is the
    // first cycle after it). A second start is pulsed at restart_k if > 1.
    task automatic run_load(input string tag, input int restart_k,
                            output int done_at, output int done_cnt, output int post_stb);
        done_at = -1; done_cnt = 0; post_stb = 0;
        @(negedge wb_clk_i);
        start_i = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge wb_clk_i);
            if (k == 1) begin
                start_i = 1'b0;
                chk({tag, "_busy1"}, 32'(busy_o), 32'd1);
                chk({tag, "_cyc1"}, 32'(wb_cyc_o), 32'd1);
                chk({tag, "_errclr"}, 32'(err_o), 32'd0);
            end
            if (restart_k > 1 && k == restart_k) start_i = 1'b1;
            if (restart_k > 1 && k == restart_k + 1) start_i = 1'b0;
            if (done_o) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (done_at > 0 && k > done_at && wb_stb_o) post_stb++;
            if (done_at > 0 && k >= done_at + 4) break;
        end
        start_i = 1'b0;
        if (done_at < 0) chk({tag, "_done_seen"}, 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    int d_at, d_cnt, p_stb_cnt;
    int found;

    initial begin
        exp_adr[0] = 32'h3000_0000; exp_dat[0] = 32'h0000_4001;
        exp_adr[1] = 32'h3000_0004; exp_dat[1] = 32'hFFFF_C000;
        exp_adr[2] = 32'h3000_0008; exp_dat[2] = 32'h0000_2000;
        exp_adr[3] = 32'h3000_000C; exp_dat[3] = 32'h0000_0001;
        exp_adr[4] = 32'h3000_0010; exp_dat[4] = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        clear_slave();
        a11_i = 16'h4001; a12_i = 16'hC000; b10_i = 16'h2000; b11_i = 16'h0001; b12_i = 16'hFFFF;

        // reset state
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk("rst_ctl", {25'd0, wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o, err_o, 1'b0},
            32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_sel", 32'(wb_sel_o), 32'd0);
        chk("rst_code", {27'd0, err_code_o, err_idx_o}, 32'd0);

        // zero-wait load
        clear_slave();
        run_load("zw", 0, d_at, d_cnt, p_stb_cnt);
        chk("zw_done_at", 32'(d_at), VER ? 32'd20 : 32'd10);
        chk("zw_done_cnt", 32'(d_cnt), 32'd1);
        chk("zw_err", 32'(err_o), 32'd0);
        check_writes("zw", 5);

        // three wait states on idx 2
        clear_slave();
        wait_cyc[2] = 3;
        run_load("ws", 0, d_at, d_cnt, p_stb_cnt);
        chk("ws_done_at", 32'(d_at), VER ? 32'd26 : 32'd13);
        chk("ws_maxrun", 32'(max_run), 32'd4);
        chk("ws_stable", 32'(unstable), 32'd0);
        chk("ws_err", 32'(err_o), 32'd0);
        check_writes("ws", 5);

        // registered-ack slave
        clear_slave();
        for (int i = 0; i < 5; i++) wait_cyc[i] = 1;
        run_load("ra", 0, d_at, d_cnt, p_stb_cnt);
        chk("ra_done_at", 32'(d_at), VER ? 32'd30 : 32'd15);
        chk("ra_maxrun", 32'(max_run), 32'd2);

        // idx 1 never acked -> timeout
        clear_slave();
        noack_at = 1;
        run_load("to", 0, d_at, d_cnt, p_stb_cnt);
        chk("to_done_at", 32'(d_at), 32'd18);
        chk("to_done_cnt", 32'(d_cnt), 32'd1);
        chk("to_maxrun", 32'(max_run), 32'd15);
        chk("to_err", 32'(err_o), 32'd1);
        chk("to_code", 32'(err_code_o), 32'd2);
        chk("to_idx", 32'(err_idx_o), 32'd1);
        chk("to_cyc", 32'(wb_cyc_o), 32'd0);
        chk("to_post", 32'(p_stb_cnt), 32'd0);
        check_writes("to", 1);

        // err together with ack on idx 3
        clear_slave();
        err_at = 3;
        run_load("be", 0, d_at, d_cnt, p_stb_cnt);
        chk("be_done_at", 32'(d_at), 32'd8);
        chk("be_code", 32'(err_code_o), 32'd1);
        chk("be_idx", 32'(err_idx_o), 32'd3);
        chk("be_err", 32'(err_o), 32'd1);
        chk("be_post", 32'(p_stb_cnt), 32'd0);
        check_writes("be", 3);

`ifdef BQLD_VERIFY_EN
        // readback returns 16'h4000 for a11
        clear_slave();
        corrupt_at = 0;
        run_load("vf", 0, d_at, d_cnt, p_stb_cnt);
        chk("vf_done_at", 32'(d_at), 32'd12);
        chk("vf_code", 32'(err_code_o), 32'd3);
        chk("vf_idx", 32'(err_idx_o), 32'd0);
        chk("vf_err", 32'(err_o), 32'd1);
`endif

        // reset during WR of idx 2, stray ack, then clean start with a
        // second start pulsed while busy
        clear_slave();
        wait_cyc[2] = 10;
        found = 0;
        @(negedge wb_clk_i);
        start_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge wb_clk_i);
            start_i = 1'b0;
            if (wb_stb_o && wb_adr_o == 32'h3000_0008) begin
                found = 1;
                break;
            end
        end
        chk("mr_found", 32'(found), 32'd1);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        chk("mr_ctl", {26'd0, wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o, err_o}, 32'd0);
        chk("mr_bus", wb_adr_o | wb_dat_o | 32'(wb_sel_o), 32'd0);
        force_ack = 1'b1;
        @(negedge wb_clk_i);
        force_ack = 1'b0;
        @(negedge wb_clk_i);
        chk("mr_ack_ign", {28'd0, wb_cyc_o, busy_o, done_o, err_o}, 32'd0);

        clear_slave();
        run_load("rs", 4, d_at, d_cnt, p_stb_cnt);
        chk("rs_done_at", 32'(d_at), VER ? 32'd20 : 32'd10);
        chk("rs_done_cnt", 32'(d_cnt), 32'd1);
        chk("rs_err", 32'(err_o), 32'd0);
        chk("rs_post", 32'(p_stb_cnt), 32'd0);
        check_writes("rs", 5);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bq_coef_loader.md
# bq_coef_loader

Wishbone master that loads the five biquad coefficients (a11, a12, b10, b11, b12) into the filter's coefficient register file. On a start pulse it latches the five values and issues five single write cycles to consecutive word addresses. It reports completion, bus errors and ack timeouts, and can optionally read every register back to check it. It sits on the initiator side of the filter's Wishbone slave port, driven by local control logic instead of the management SoC.

## Interface
- COEFWIDTH, 16: coefficient width; value occupies wb_dat_o[COEFWIDTH-1:0], sign-extended to 32 bits
- BASE_ADDR, 32'h3000_0000: byte address of coefficient 0 (a11)
- TIMEOUT, 15: max cycles stb may stay high without ack/err (4..255)

- wb_clk_i  in  1  the single clock
- wb_rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  begin load; sampled only in IDLE
- a11_i, a12_i, b10_i, b11_i, b12_i  in  COEFWIDTH each  coefficient values, latched on accepted start
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  32  BASE_ADDR + 4*idx
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  always 4'hF while stb high, else 0
- wb_dat_i  in  32  read data (verify only)
- wb_ack_i  in  1  slave ack
- wb_err_i  in  1  slave error
- busy_o  out  1  high from cycle after accepted start until done_o
- done_o  out  1  one-cycle pulse at end (success or failure)
- err_o  out  1  sticky failure flag, cleared on next accepted start
- err_code_o  out  2  01 bus error, 10 timeout, 11 verify mismatch, 00 none
- err_idx_o  out  3  index (0..4) of failing register

## Operation
- Index order: 0 a11, 1 a12, 2 b10, 3 b11, 4 b12.
- States: IDLE, WR, GAP, RD (VERIFY only), FIN, FAIL.
- IDLE: start_i=1 latches the coefficients, sets idx=0, clears err_o/err_code_o/err_idx_o, and moves to WR.
- WR: cyc=stb=we=1 with adr/dat for idx. On ack:
  - idx<4: go to GAP.
  - idx==4: go to FIN, or with verify go to GAP then RD with idx=0.
- GAP: cyc=stb=0 for exactly one cycle, then increment idx and go to WR or RD.
- RD: cyc=stb=1, we=0, wb_dat_o=0. On ack, compare wb_dat_i[COEFWIDTH-1:0] with the latched value.
  - Mismatch: go to FAIL with code 11.
  - Match and idx<4: go to GAP.
  - Match and idx==4: go to FIN.
- wb_err_i while stb is high: go to FAIL with code 01, regardless of ack. Err wins if ack and err arrive together.
- Timeout counter resets on each stb rising. When stb has been high TIMEOUT cycles with no ack/err, go to FAIL with code 10.
- FIN/FAIL: one cycle with done_o=1 and cyc=stb=0, then IDLE. FAIL also sets err_o, err_code_o and err_idx_o=idx.
- start_i is ignored outside IDLE. Ack/err outside stb-high cycles are ignored.

## Timing
- Reset values: all wb_*_o = 0, busy_o=0, done_o=0, err_o=0, err_code_o=0, err_idx_o=0, state IDLE.
- Reset asserted mid-transfer drops cyc/stb at the next edge. A later ack has no effect.
- start_i accepted at edge n: cyc/stb high from cycle n+1.
- With ack in the first stb cycle, each transfer takes 2 cycles (WR + GAP).
- Write-only load with zero-wait slave: done_o at cycle n+10 (5 WR + 4 GAP + FIN).
- Registered-ack slave (ack one cycle after stb): each WR lasts 2 cycles, done_o at n+15.
- All outputs are registered. There is no combinational path from wb_ack_i to any output.

## Configuration
- BQLD_VERIFY_EN defined: the readback phase (RD state, mismatch check, code 11) is compiled in. Load length is 10 transfers; done_o at n+20 with a zero-wait slave.
- BQLD_VERIFY_EN undefined: the RD state and comparator are absent, wb_we_o is high whenever stb is high, and err_code_o never reports 11.

## Test plan
- Zero-wait slave, start with a11=16'h4001, a12=16'hC000, b10=16'h2000, b11=16'h0001, b12=16'hFFFF -> five writes to 0x3000_0000..0x3000_0010. Data 0x0000_4001, 0xFFFF_C000, 0x0000_2000, 0x0000_0001, 0xFFFF_FFFF. done_o at n+10, err_o=0.
- Slave holds ack low for 3 cycles on idx 2 -> stb stays high 4 cycles, addresses and data held stable, no error, done_o at n+13.
- Slave never acks idx 1 -> FAIL after 15 stb-high cycles with err_code_o=10, err_idx_o=1, cyc drops, done_o pulses once.
- wb_err_i together with wb_ack_i on idx 3 -> err_code_o=01, err_idx_o=3, no further transfers.
- VERIFY build, slave returns 16'h4000 for a11 written as 16'h4001 -> err_code_o=11, err_idx_o=0. Correct slave -> done_o at n+20, err_o=0.
- wb_rst_i pulsed during WR of idx 2, then start_i pulsed during busy -> all outputs 0 after reset. A fresh start begins at idx 0, and a start during busy does not restart the sequence.
